// File: rtl/capture_readout_pkg.sv
// capture_readout_pkg: readout FSM encoding and capture RAM geometry shared with the writer
package capture_readout_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 10;
   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;
endpackage

// File: rtl/readout_skid_buf.sv
// readout_skid_buf: 2-entry fall-through valid/ready buffer with occupancy output
module readout_skid_buf #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [1:0]        occ
);
   logic [DATA_W-1:0] mem_q [2];
   logic [DATA_W-1:0] mem_d [2];
   logic [1:0] occ_q, occ_d;
   logic head_q, head_d, push, pop, wr_idx;
   always_comb begin
      pop = occ_q != 2'd0 && out_ready;
      push = in_valid && !(occ_q == 2'd0 && out_ready);
      wr_idx = head_q ^ occ_q[0];
      mem_d = mem_q;
      if (push) mem_d[wr_idx] = in_data;
      occ_d = flush ? 2'd0 : occ_q + 2'(push) - 2'(pop);
      head_d = flush ? 1'b0 : head_q ^ pop;
      out_valid = occ_q != 2'd0 || in_valid;
      out_data = occ_q != 2'd0 ? mem_q[head_q] : in_valid ? in_data : '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q <= 2'd0;
         head_q <= 1'b0;
      end else begin
         occ_q <= occ_d;
         head_q <= head_d;
      end
   end
   always_ff @(posedge clk) mem_q <= mem_d;
   assign occ = occ_q;
endmodule

// File: rtl/capture_readout.sv
// capture_readout: streams count samples from the circular capture RAM as a valid/ready byte stream
module capture_readout
   import capture_readout_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] count,
   output logic              ram_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   sent
);
   state_t state_q, state_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0] rem_q, rem_d, sent_q, sent_d;
   logic inflight_q, inflight_d, done_q, done_d, flush, xfer, credit_ok;
   logic [1:0] occ;
   readout_skid_buf #(.DATA_W(DATA_W)) u_skid (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .in_valid(inflight_q),
      .in_data(ram_rdata),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_ready(out_ready),
      .occ(occ)
   );
   // a read is issued only when its sample is guaranteed a buffer slot
   always_comb begin
      credit_ok = ({1'b0, inflight_q} + occ) < 2'd2;
      ram_en = state_q == ST_READ && rem_q != '0 && credit_ok && !abort;
      xfer = out_valid && out_ready;
      state_d = state_q;
      rd_ptr_d = rd_ptr_q;
      rem_d = rem_q;
      inflight_d = ram_en;
      sent_d = sent_q + (ADDR_W+1)'(xfer);
      done_d = 1'b0;
      flush = abort;
      if (ram_en) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         rem_d = rem_q - (ADDR_W+1)'(1);
      end
      if (abort) state_d = ST_IDLE;
      else if (state_q == ST_IDLE && start) begin
         rd_ptr_d = start_addr;
         rem_d = count == '0 ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, count};
         sent_d = '0;
         state_d = ST_READ;
      end else if (state_q == ST_READ && rem_q == '0) state_d = ST_DRAIN;
      else if (state_q == ST_DRAIN && occ == 2'd0 && !inflight_q) begin
         state_d = ST_IDLE;
         done_d = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         rd_ptr_q <= '0;
         rem_q <= '0;
         inflight_q <= 1'b0;
         sent_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_ptr_q <= rd_ptr_d;
         rem_q <= rem_d;
         inflight_q <= inflight_d;
         sent_q <= sent_d;
         done_q <= done_d;
      end
   end
   assign ram_addr = rd_ptr_q;
   assign busy = state_q != ST_IDLE;
   assign done = done_q;
   assign sent = sent_q;
endmodule

// File: tb/tb_capture_readout.sv
// tb_capture_readout: directed checks of capture_readout against a 1-cycle RAM holding mem[i]=i
module tb_capture_readout;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic out_ready = 1'b1;
   logic [3:0] start_addr = 4'd0;
   logic [3:0] count = 4'd0;
   logic [3:0] ram_addr;
   logic [7:0] ram_rdata = 8'd0;
   logic [7:0] out_data;
   logic ram_en, out_valid, busy, done;
   logic [4:0] sent;
   int checks = 0;
   int failures = 0;

   capture_readout #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .abort(abort),
      .start_addr(start_addr),
      .count(count),
      .ram_en(ram_en),
      .ram_addr(ram_addr),
      .ram_rdata(ram_rdata),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy(busy),
      .done(done),
      .sent(sent)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (ram_en) ram_rdata <= {4'h0, ram_addr};

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic rdy);
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      out_ready = rdy;
      #1;
   endtask

   task automatic do_start(input int a, input int c);
      @(posedge clk);
      #1;
      start_addr = 4'(a);
      count = 4'(c);
      start = 1'b1;
      abort = 1'b0;
   endtask

   task automatic stream(input string tag, input int first, input int cnt, input int n,
                         input bit rnd, input bit glitch);
      int got = 0, issued = 0, dones = 0, cyc = 0, t_first = -1, t_last = -1, first_en = -1;
      int bad_order = 0, bad_addr = 0, bad_stall = 0, bad_occ = 0, extra = 0;
      logic prev_stall = 1'b0;
      logic [7:0] prev_data = 8'd0;
      do_start(first, cnt);
      while (dones == 0 && cyc < 400) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
         if (glitch && cyc == 2) begin
            start = 1'b1;
            start_addr = 4'd9;
            count = 4'd3;
         end
         #1;
         if (prev_stall && !(out_valid && out_data == prev_data)) bad_stall++;
         if (ram_en) begin
            if (first_en < 0) first_en = cyc;
            if (ram_addr != 4'((first + issued) % 16)) bad_addr++;
            issued++;
         end
         if (issued - got > 2) bad_occ++;
         if (out_valid && out_ready) begin
            if (out_data != 8'((first + got) % 16)) bad_order++;
            if (t_first < 0) t_first = cyc;
            t_last = cyc;
            got++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data = out_data;
         if (done) dones++;
         cyc++;
      end
      chk({tag, "_sent"}, int'(sent), n);
      chk({tag, "_busy"}, int'(busy), 0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1);
         if (done || out_valid || ram_en) extra++;
      end
      chk({tag, "_order"}, bad_order, 0);
      chk({tag, "_addr"}, bad_addr, 0);
      chk({tag, "_stall"}, bad_stall, 0);
      chk({tag, "_buffered"}, bad_occ, 0);
      chk({tag, "_count"}, got, n);
      chk({tag, "_done"}, dones, 1);
      chk({tag, "_after"}, extra, 0);
      chk({tag, "_first_en"}, first_en, 0);
      if (!rnd) begin
         chk({tag, "_first_valid"}, t_first, 1);
         chk({tag, "_span"}, t_last - t_first, n - 1);
      end
   endtask

   initial begin
      int got = 0, cyc = 0, late_done = 0;
      repeat (3) tick(1'b1);
      chk("rst_ram_en", int'(ram_en), 0);
      chk("rst_ram_addr", int'(ram_addr), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_sent", int'(sent), 0);
      @(posedge clk);
      #1 reset = 1'b0;

      do_start(3, 4);
      abort = 1'b1;
      tick(1'b1);
      chk("start_abort_busy", int'(busy), 0);
      chk("start_abort_ram_en", int'(ram_en), 0);

      stream("basic", 5, 4, 4, 1'b0, 1'b0);
      stream("wrap", 14, 4, 4, 1'b0, 1'b0);
      stream("full", 0, 0, 16, 1'b0, 1'b0);
      stream("stall", 0, 8, 8, 1'b1, 1'b0);

      do_start(0, 10);
      while (got < 3 && cyc < 50) begin
         tick(1'b1);
         if (out_valid && out_ready) got++;
         cyc++;
      end
      @(posedge clk);
      #1;
      abort = 1'b1;
      out_ready = 1'b0;
      tick(1'b0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_ram_en", int'(ram_en), 0);
      chk("abort_sent", int'(sent), 3);
      for (int i = 0; i < 5; i++) begin
         tick(1'b1);
         if (done || out_valid) late_done++;
      end
      chk("abort_quiet", late_done, 0);
      chk("abort_sent_hold", int'(sent), 3);
      stream("restart", 0, 10, 10, 1'b0, 1'b0);

      do_start(3, 10);
      repeat (3) tick(1'b1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("midrst_ram_en", int'(ram_en), 0);
      chk("midrst_ram_addr", int'(ram_addr), 0);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_out_data", int'(out_data), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_sent", int'(sent), 0);

      stream("busy_start", 2, 6, 6, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
